// File: rtl/updown_counter_pkg.sv
// Shared types for the up/down counter bank: opcodes, channel states, count modes.
package updown_counter_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_SET_LO = 3'd1,
    OP_SET_HI = 3'd2,
    OP_LOAD   = 3'd3,
    OP_START  = 3'd4,
    OP_STOP   = 3'd5,
    OP_CLEAR  = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_e;

  typedef enum logic {
    M_PINGPONG = 1'b0,
    M_WRAP     = 1'b1
  } mode_e;

  // NOP and the reserved opcode leave the channel free to step that cycle.
  function automatic logic op_has_effect(input logic [2:0] op);
    return (op != OP_NOP) && (op != OP_RSVD);
  endfunction

endpackage

// File: rtl/updown_counter_channel.sv
// One counter channel: limit/mode registers, IDLE/UP/DOWN FSM and the step rules.
module updown_counter_channel
  import updown_counter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_hit_i,
  input  logic [2:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  output logic [WIDTH-1:0] value_o,
  output logic             running_o,
  output logic             dir_o,
  output logic             turn_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] value_q, lo_q, hi_q;
  state_e           state_q;
  mode_e            mode_q;
  logic             turn_q;
  logic             cmd_act;
  logic             step_en;

  assign cmd_act = cmd_hit_i && op_has_effect(cmd_op_i);
  // lo >= hi freezes the channel in place; this also keeps +1/-1 inside WIDTH bits.
  assign step_en = (state_q != S_IDLE) && (lo_q < hi_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      lo_q    <= '0;
      hi_q    <= '1;
      mode_q  <= M_PINGPONG;
      state_q <= S_IDLE;
      turn_q  <= 1'b0;
    end else begin
      turn_q <= 1'b0;
      if (cmd_act) begin
        case (op_e'(cmd_op_i))
          OP_SET_LO: lo_q <= cmd_data_i;
          OP_SET_HI: hi_q <= cmd_data_i;
          OP_LOAD: begin
            value_q <= cmd_data_i;
            state_q <= S_IDLE;
          end
          OP_START: begin
            mode_q  <= mode_e'(cmd_data_i[0]);
            state_q <= S_UP;
          end
          OP_STOP:  state_q <= S_IDLE;
          OP_CLEAR: begin
            value_q <= lo_q;
            state_q <= S_IDLE;
          end
          default: ;
        endcase
      end else if (step_en) begin
        case (state_q)
          S_UP: begin
            if (value_q < hi_q) begin
              value_q <= value_q + ONE;
            end else if (mode_q == M_WRAP) begin
              value_q <= lo_q;
              turn_q  <= 1'b1;
            end else begin
              state_q <= S_DOWN;
              value_q <= value_q - ONE;
              turn_q  <= 1'b1;
            end
          end
          S_DOWN: begin
            if (value_q > lo_q) begin
              value_q <= value_q - ONE;
            end else begin
              state_q <= S_UP;
              value_q <= value_q + ONE;
              turn_q  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign value_o   = value_q;
  assign running_o = (state_q != S_IDLE);
  assign dir_o     = (state_q == S_DOWN);
  assign turn_o    = turn_q;

endmodule

// File: rtl/updown_counter_fsm.sv
// Bank of CHANNELS up/down counters behind one valid/ready command port.
module updown_counter_fsm
  import updown_counter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [CH_BITS-1:0]        cmd_ch,
  input  logic [2:0]                cmd_op,
  input  logic [WIDTH-1:0]          cmd_data,
  output logic [CHANNELS*WIDTH-1:0] count_flat,
  output logic [CHANNELS-1:0]       running,
  output logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS-1:0]       turn
);

  logic accept;

  assign cmd_ready = ~rst;
  assign accept    = cmd_valid && cmd_ready;

  // Channel selects past CHANNELS-1 match no instance and are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic hit;
    assign hit = accept && (int'(cmd_ch) == i);

    updown_counter_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .cmd_hit_i (hit),
      .cmd_op_i  (cmd_op),
      .cmd_data_i(cmd_data),
      .value_o   (count_flat[i*WIDTH +: WIDTH]),
      .running_o (running[i]),
      .dir_o     (dir[i]),
      .turn_o    (turn[i])
    );
  end

endmodule

// File: tb/tb_updown_counter_fsm.sv
// Bench for updown_counter_fsm: directed table, corner sequences, random vs. reference model.
module tb_updown_counter_fsm;

  localparam int W  = 8;
  localparam int CH = 3;
  localparam int CB = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [CB-1:0]   cmd_ch;
  logic [2:0]      cmd_op;
  logic [W-1:0]    cmd_data;
  logic [CH*W-1:0] count_flat;
  logic [CH-1:0]   running, dir, turn;

  updown_counter_fsm #(.WIDTH(W), .CHANNELS(CH), .CH_BITS(CB)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .count_flat(count_flat), .running(running), .dir(dir), .turn(turn)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: plain integers, direction kept as a signed step (0 = stopped).
  int unsigned m_v[CH], m_lo[CH], m_hi[CH];
  int          m_step[CH];
  bit          m_wrap[CH];
  bit          m_turn[CH];

  typedef struct {
    bit       v;
    int       op;
    int       data;
    int       exp_v;
    bit       exp_turn;
    bit       exp_dir;
    bit       exp_run;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void model_clk(input bit r, input bit v, input int c, input int op, input int unsigned d);
    for (int k = 0; k < CH; k++) begin
      if (r) begin
        m_v[k] = 0; m_lo[k] = 0; m_hi[k] = (1 << W) - 1;
        m_step[k] = 0; m_wrap[k] = 0; m_turn[k] = 0;
      end else begin
        m_turn[k] = 0;
        if (v && c == k && op >= 1 && op <= 6) begin
          if (op == 1) m_lo[k] = d;
          if (op == 2) m_hi[k] = d;
          if (op == 3) begin m_v[k] = d; m_step[k] = 0; end
          if (op == 4) begin m_wrap[k] = d[0]; m_step[k] = 1; end
          if (op == 5) m_step[k] = 0;
          if (op == 6) begin m_v[k] = m_lo[k]; m_step[k] = 0; end
        end else if (m_step[k] != 0 && m_lo[k] < m_hi[k]) begin
          if (m_step[k] > 0 && m_v[k] >= m_hi[k]) begin
            m_turn[k] = 1;
            if (m_wrap[k]) m_v[k] = m_lo[k];
            else begin m_step[k] = -1; m_v[k] = m_v[k] - 1; end
          end else if (m_step[k] < 0 && m_v[k] <= m_lo[k]) begin
            m_turn[k] = 1;
            m_step[k] = 1;
            m_v[k] = m_v[k] + 1;
          end else begin
            m_v[k] = int'(m_v[k]) + m_step[k];
          end
        end
      end
    end
  endfunction

  task automatic compare_all(input bit r);
    chk("cmd_ready", 32'(cmd_ready), 32'(!r));
    for (int k = 0; k < CH; k++) begin
      chk($sformatf("ch%0d value", k), 32'(count_flat[k*W +: W]), m_v[k]);
      chk($sformatf("ch%0d running", k), 32'(running[k]), 32'(m_step[k] != 0));
      chk($sformatf("ch%0d dir", k), 32'(dir[k]), 32'(m_step[k] < 0));
      chk($sformatf("ch%0d turn", k), 32'(turn[k]), 32'(m_turn[k]));
    end
  endtask

  task automatic cyc(input bit r, input bit v, input int c, input int op, input int d);
    rst = r; cmd_valid = v; cmd_ch = c[CB-1:0]; cmd_op = op[2:0]; cmd_data = d[W-1:0];
    @(posedge clk);
    model_clk(r, v, c, op, int'(d[W-1:0]));
    #1;
    compare_all(r);
  endtask

  function automatic int val(input int k);
    return int'(count_flat[k*W +: W]);
  endfunction

  initial begin
    // Ping-pong on ch0 between 2 and 5, one table row per clock.
    tbl[0]  = '{1, 1, 2, 0, 0, 0, 0};
    tbl[1]  = '{1, 2, 5, 0, 0, 0, 0};
    tbl[2]  = '{1, 3, 2, 2, 0, 0, 0};
    tbl[3]  = '{1, 4, 0, 2, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 3, 0, 0, 1};
    tbl[5]  = '{0, 0, 0, 4, 0, 0, 1};
    tbl[6]  = '{0, 0, 0, 5, 0, 0, 1};
    tbl[7]  = '{0, 0, 0, 4, 1, 1, 1};
    tbl[8]  = '{0, 0, 0, 3, 0, 1, 1};
    tbl[9]  = '{0, 0, 0, 2, 0, 1, 1};
    tbl[10] = '{0, 0, 0, 3, 1, 0, 1};
    tbl[11] = '{0, 0, 0, 4, 0, 0, 1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; cmd_op = '0; cmd_data = '0;

    // Reset held two cycles with a command pending.
    cyc(1, 1, 0, 3, 5);
    cyc(1, 1, 0, 3, 5);
    chk("reset count_flat", 32'(count_flat), 32'(0));
    chk("reset running", 32'(running), 32'(0));
    cyc(0, 0, 0, 0, 0);
    chk("ready after reset", 32'(cmd_ready), 32'(1));

    for (int i = 0; i < 12; i++) begin
      cyc(0, tbl[i].v, 0, tbl[i].op, tbl[i].data);
      chk($sformatf("tbl%0d value", i), 32'(val(0)), 32'(tbl[i].exp_v));
      chk($sformatf("tbl%0d turn", i), 32'(turn[0]), 32'(tbl[i].exp_turn));
      chk($sformatf("tbl%0d dir", i), 32'(dir[0]), 32'(tbl[i].exp_dir));
      chk($sformatf("tbl%0d running", i), 32'(running[0]), 32'(tbl[i].exp_run));
    end

    // Wrap at the top of the range on ch1.
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 2, 255);
    cyc(0, 1, 1, 3, 254);
    cyc(0, 1, 1, 4, 1);
    chk("wrap start", 32'(val(1)), 32'(254));
    cyc(0, 0, 0, 0, 0);
    chk("wrap 255", 32'(val(1)), 32'(255));
    cyc(0, 0, 0, 0, 0);
    chk("wrap 0", 32'(val(1)), 32'(0));
    chk("wrap turn", 32'(turn[1]), 32'(1));
    cyc(0, 0, 0, 0, 0);
    chk("wrap 1", 32'(val(1)), 32'(1));
    cyc(0, 1, 1, 5, 0);
    chk("stop value", 32'(val(1)), 32'(1));
    chk("stop running", 32'(running[1]), 32'(0));

    // Collision: LOAD on running ch0 while ch2 counts.
    cyc(0, 1, 2, 4, 0);
    cyc(0, 0, 0, 0, 0);
    begin
      int prev2;
      prev2 = val(2);
      cyc(0, 1, 0, 3, 9);
      chk("collide ch0 value", 32'(val(0)), 32'(9));
      chk("collide ch0 running", 32'(running[0]), 32'(0));
      chk("collide ch2 step", 32'(val(2)), 32'(prev2 + 1));
    end

    // Degenerate limits on ch2.
    cyc(0, 1, 2, 1, 7);
    cyc(0, 1, 2, 2, 7);
    cyc(0, 1, 2, 3, 7);
    cyc(0, 1, 2, 4, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("degen value", 32'(val(2)), 32'(7));
      chk("degen running", 32'(running[2]), 32'(1));
      chk("degen turn", 32'(turn[2]), 32'(0));
    end
    begin
      logic [CH*W-1:0] sv_cnt;
      logic [CH-1:0]   sv_run;
      sv_cnt = count_flat; sv_run = running;
      cyc(0, 1, CH, 3, 99);
      chk("bad ch count", 32'(count_flat), 32'(sv_cnt));
      chk("bad ch running", 32'(running), 32'(sv_run));
    end

    // Reset in the middle of activity.
    cyc(0, 1, 0, 4, 0);
    cyc(0, 1, 1, 4, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 3, 5);
    chk("midrst count", 32'(count_flat), 32'(0));
    chk("midrst running", 32'(running), 32'(0));
    cyc(0, 1, 0, 3, 254);
    cyc(0, 1, 0, 4, 1);
    cyc(0, 0, 0, 0, 0);
    chk("midrst hi restored", 32'(val(0)), 32'(255));
    cyc(0, 0, 0, 0, 0);
    chk("midrst lo restored", 32'(val(0)), 32'(0));
    chk("midrst wrap turn", 32'(turn[0]), 32'(1));

    // Random traffic with small operands so limits and turns are hit often.
    for (int i = 0; i < 600; i++) begin
      bit r, v;
      int c, op, d;
      r  = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 2) != 0);
      c  = int'($urandom_range(0, 3));
      op = int'($urandom_range(0, 7));
      d  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      cyc(r, v, c, op, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
